multiply_divide_unit: RTL and testbench

Multi-cycle signed/unsigned multiply/divide unit with HI/LO registers for the pipelined MIPS core, sitting in the EX stage beside the ALU. It accepts an operation and two 32-bit operands on a one-cycle start pulse, holds `busy` for a fixed latency, then commits the result to HI/LO. Its signed/unsigned operand interpretation matches the comparer's `signed_comp` convention. The hazard unit stalls HI/LO-dependent instructions on `start | busy`.

---
 rtl/multiply_divide_unit.sv | 128 ++++++++++++
 tb/tb_multiply_divide_unit.sv | 112 +++++++++++
 2 files changed

// File: rtl/multiply_divide_unit.sv
// Multi-cycle signed/unsigned multiply/divide unit with HI/LO registers.
// Results are computed at acceptance and committed to HI/LO after a fixed latency.
module multiply_divide_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);
  // state | meaning
  // IDLE  | ready; accepts mult/div/mthi/mtlo
  // MUL   | multiply latency window, result pending in hi_n/lo_n
  // DIV   | divide latency window, result pending in hi_n/lo_n
  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  localparam int MAXC  = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W = $clog2(MAXC + 1);

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [31:0]        hi_n, lo_n;
  logic               accept, load_mul, load_div, commit, wr_hi, wr_lo;
  logic               is_signed;
  logic [63:0]        ext_a, ext_b, prod;
  logic [31:0]        div_q, div_r;

  assign accept    = start & ~busy;
  assign is_signed = ~op[0];
  assign ext_a     = {{32{A[31] & is_signed}}, A};
  assign ext_b     = {{32{B[31] & is_signed}}, B};
  assign prod      = ext_a * ext_b;

  // Divide-by-zero and signed overflow get fixed results instead of relying on the operator.
  always_comb begin
    div_q = 32'hFFFF_FFFF;
    div_r = A;
    if (B == 32'h0) begin
      div_q = 32'hFFFF_FFFF;
      div_r = A;
    end else if (is_signed && A == 32'h8000_0000 && B == 32'hFFFF_FFFF) begin
      div_q = 32'h8000_0000;
      div_r = 32'h0;
    end else if (is_signed) begin
      div_q = $unsigned($signed(A) / $signed(B));
      div_r = $unsigned($signed(A) % $signed(B));
    end else begin
      div_q = A / B;
      div_r = A % B;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    load_mul = 1'b0;
    load_div = 1'b0;
    commit   = 1'b0;
    wr_hi    = 1'b0;
    wr_lo    = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          case (op)
            3'd0, 3'd1: begin
              state_n  = MUL;
              cnt_n    = CNT_W'(MULT_CYCLES - 1);
              load_mul = 1'b1;
            end
            3'd2, 3'd3: begin
              state_n  = DIV;
              cnt_n    = CNT_W'(DIV_CYCLES - 1);
              load_div = 1'b1;
            end
            3'd4:    wr_hi = 1'b1;
            3'd5:    wr_lo = 1'b1;
            default: ;
          endcase
        end
      end
      MUL, DIV: begin
        if (cnt == '0) begin
          commit  = 1'b1;
          state_n = IDLE;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      hi_n  <= 32'h0;
      lo_n  <= 32'h0;
      HI    <= 32'h0;
      LO    <= 32'h0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      busy  <= (state_n != IDLE);
      if (load_mul) begin
        hi_n <= prod[63:32];
        lo_n <= prod[31:0];
      end else if (load_div) begin
        hi_n <= div_r;
        lo_n <= div_q;
      end
      if (commit) begin
        HI <= hi_n;
        LO <= lo_n;
      end else begin
        if (wr_hi) HI <= A;
        if (wr_lo) LO <= A;
      end
    end
  end
endmodule

// File: tb/tb_multiply_divide_unit.sv
// Directed bench for multiply_divide_unit: expected HI/LO pairs are queued at issue
// and compared when the unit goes idle again.
module tb_multiply_divide_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] A = 32'h0;
  logic [31:0] B = 32'h0;
  logic        busy;
  logic [31:0] HI, LO;

  int checks = 0;
  int errors = 0;
  logic [63:0] sb_q[$];

  multiply_divide_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
    .busy(busy), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one op, scramble operands during busy, count busy cycles, then check the commit.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input int n, input logic [31:0] eh,
                        input logic [31:0] el);
    logic [31:0] old_hi, old_lo;
    logic [63:0] exp;
    int cycles;
    @(negedge clk);
    start = 1'b1; op = o; A = a; B = b;
    sb_q.push_back({eh, el});
    old_hi = HI; old_lo = LO;
    @(negedge clk);
    start = 1'b0; A = $urandom; B = $urandom;
    cycles = 0;
    while (busy === 1'b1 && cycles < 40) begin
      cycles++;
      chk({tag, "_hold"}, {HI, LO}, {old_hi, old_lo});
      @(negedge clk);
    end
    chk({tag, "_busy_cycles"}, 64'(cycles), 64'(n));
    exp = sb_q.pop_front();
    chk({tag, "_result"}, {HI, LO}, exp);
  endtask

  initial begin
    @(negedge clk);
    chk("reset_state", {31'h0, busy, HI, LO}, 64'h0);
    @(posedge clk); #1 reset = 1'b0;

    run_op("mult_signed",   3'd0, 32'hFFFF_FFFE, 32'd3,         5,  32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_op("multu",         3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5,  32'hFFFF_FFFE, 32'h0000_0001);
    run_op("div_signed",    3'd2, 32'hFFFF_FFF9, 32'd2,         10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu",          3'd3, 32'hFFFF_FFF9, 32'd2,         10, 32'h0000_0001, 32'h7FFF_FFFC);
    run_op("divu_by_zero",  3'd3, 32'd5,         32'd0,         10, 32'h0000_0005, 32'hFFFF_FFFF);
    run_op("div_by_zero",   3'd2, 32'hFFFF_FFF7, 32'd0,         10, 32'hFFFF_FFF7, 32'hFFFF_FFFF);
    run_op("div_overflow",  3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0000_0000, 32'h8000_0000);
    run_op("mthi",          3'd4, 32'h5555_0001, 32'd0,         0,  32'h5555_0001, 32'h8000_0000);
    run_op("noop7",         3'd7, 32'hDEAD_BEEF, 32'd1,         0,  32'h5555_0001, 32'h8000_0000);

    // mthi arriving one cycle after a mult is accepted must be dropped.
    @(negedge clk);
    start = 1'b1; op = 3'd0; A = 32'd7; B = 32'd6;
    @(negedge clk);
    chk("ignored_busy", 64'(busy), 64'd1);
    op = 3'd4; A = 32'h1234;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("ignored_mthi_result", {31'h0, busy, HI, LO}, {32'h0, 32'h0, 32'h0000_002A});
    run_op("mtlo", 3'd5, 32'hABCD, 32'd0, 0, 32'h0, 32'hABCD);

    // Reset 4 cycles into a div: immediate clear, no late commit.
    run_op("pre_reset_mult", 3'd1, 32'd3, 32'd4, 5, 32'h0, 32'd12);
    @(negedge clk);
    start = 1'b1; op = 3'd3; A = 32'd100; B = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("reset_mid_op", {31'h0, busy, HI, LO}, 64'h0);
    @(negedge clk);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    chk("no_commit_after_reset", {31'h0, busy, HI, LO}, 64'h0);

    // Second abort, then a mult on the very first edge after release.
    @(negedge clk);
    start = 1'b1; op = 3'd2; A = 32'd50; B = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    run_op("mult_after_reset", 3'd0, 32'hFFFF_FFFF, 32'd5, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFB);

    chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
